// File: rtl/rtc_write_arbiter.sv
// Round-robin arbiter sharing the DS3231 time-set write port
// between the UART and host/network requesters.
module rtc_write_arbiter #(
    parameter int TIMEOUT_CYC = 5000000,
    parameter int DW          = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] dat0,
    output logic          done0,
    output logic          err0,
    input  logic          req1,
    input  logic [DW-1:0] dat1,
    output logic          done1,
    output logic          err1,
    output logic          write_start,
    output logic [DW-1:0] write_dat,
    input  logic          write_over,
    output logic          busy,
    output logic          grant
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          pend0;
    logic          pend1;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic [CW-1:0] cnt;

    logic cool;
    logic fire;
    logic pick;
    logic fire0;
    logic fire1;
    logic at_max;
    logic done_nxt;
    logic err_nxt;

    // No grant while a done/err pulse is out: one turnaround cycle
    assign cool   = done0 | done1 | err0 | err1;
    assign fire   = (state == IDLE) && (pend0 | pend1) && !cool;
    assign pick   = (pend0 && pend1) ? ~grant : pend1;
    assign fire0  = fire && !pick;
    assign fire1  = fire && pick;
    assign at_max = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            if (req0) begin
                pend0 <= 1'b1;
                buf0  <= dat0;
            end else if (fire0) begin
                pend0 <= 1'b0;
            end
            if (req1) begin
                pend1 <= 1'b1;
                buf1  <= dat1;
            end else if (fire1) begin
                pend1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fire) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (write_over || at_max) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion beats timeout in the terminal cycle
    always_comb begin
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (state == WAIT) begin
            done_nxt = write_over;
            err_nxt  = !write_over && at_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_start <= 1'b0;
            write_dat   <= '0;
            busy        <= 1'b0;
            grant       <= 1'b1;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            cnt         <= '0;
        end else begin
            write_start <= (state_nxt == START);
            busy        <= (state_nxt != IDLE);
            done0       <= done_nxt && !grant;
            done1       <= done_nxt && grant;
            err0        <= err_nxt && !grant;
            err1        <= err_nxt && grant;
            if (fire) begin
                grant     <= pick;
                write_dat <= pick ? buf1 : buf0;
            end
            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT && !at_max) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_write_arbiter.sv
// Directed bench for rtc_write_arbiter with a short timeout.
module tb_rtc_write_arbiter;

    localparam int T  = 20;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic [DW-1:0] dat0 = '0;
    logic          done0;
    logic          err0;
    logic          req1 = 1'b0;
    logic [DW-1:0] dat1 = '0;
    logic          done1;
    logic          err1;
    logic          write_start;
    logic [DW-1:0] write_dat;
    logic          write_over = 1'b0;
    logic          busy;
    logic          grant;

    int total = 0;
    int bad   = 0;

    int n_done0 = 0;
    int n_done1 = 0;
    int n_err0  = 0;
    int n_err1  = 0;
    int n_start = 0;

    int s_done0, s_done1, s_err0, s_err1, s_start;

    rtc_write_arbiter #(.TIMEOUT_CYC(T), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .dat0(dat0),
        .done0(done0),
        .err0(err0),
        .req1(req1),
        .dat1(dat1),
        .done1(done1),
        .err1(err1),
        .write_start(write_start),
        .write_dat(write_dat),
        .write_over(write_over),
        .busy(busy),
        .grant(grant)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (err0) n_err0++;
        if (err1) n_err1++;
        if (write_start) n_start++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_done0 = n_done0;
        s_done1 = n_done1;
        s_err0  = n_err0;
        s_err1  = n_err1;
        s_start = n_start;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        tick(1);
        do_reset();
        chk("rst_start", 64'(write_start), 0);
        chk("rst_dat", 64'(write_dat), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant), 1);
        chk("rst_pulses", {60'd0, done0, done1, err0, err1}, 0);

        // single request
        snap();
        req0 = 1'b1; dat0 = 48'h0012_3456_789A;
        tick(1);
        req0 = 1'b0; dat0 = '0;
        chk("s_c1_start", 64'(write_start), 0);
        tick(1);
        chk("s_c2_start", 64'(write_start), 1);
        chk("s_c2_dat", 64'(write_dat), 64'h0012_3456_789A);
        chk("s_c2_busy", 64'(busy), 1);
        chk("s_c2_grant", 64'(grant), 0);
        tick(1);
        chk("s_c3_start", 64'(write_start), 0);
        tick(9);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("s_done0", 64'(done0), 1);
        chk("s_busy_off", 64'(busy), 0);
        tick(3);
        chk("s_n_done0", 64'(n_done0 - s_done0), 1);
        chk("s_n_other", 64'((n_done1 - s_done1) + (n_err0 - s_err0)
                           + (n_err1 - s_err1)), 0);

        // contention after reset
        do_reset();
        snap();
        req0 = 1'b1; dat0 = 48'hAAAA_0000_0001;
        req1 = 1'b1; dat1 = 48'hBBBB_0000_0002;
        tick(1);
        req0 = 1'b0; req1 = 1'b0;
        tick(1);
        chk("c_start1", 64'(write_start), 1);
        chk("c_grant1", 64'(grant), 0);
        chk("c_dat1", 64'(write_dat), 64'hAAAA_0000_0001);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("c_done0", 64'(done0), 1);
        tick(1);
        chk("c_c5_start", 64'(write_start), 0);
        tick(1);
        chk("c_start2", 64'(write_start), 1);
        chk("c_grant2", 64'(grant), 1);
        chk("c_dat2", 64'(write_dat), 64'hBBBB_0000_0002);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("c_done1", 64'(done1), 1);
        tick(3);
        chk("c_n_done0", 64'(n_done0 - s_done0), 1);
        chk("c_n_done1", 64'(n_done1 - s_done1), 1);

        // overwrite while pending
        snap();
        req0 = 1'b1; dat0 = 48'h0000_0000_0C0C;
        tick(1);
        req0 = 1'b0;
        tick(3);
        req1 = 1'b1; dat1 = 48'h0000_0000_000A;
        tick(1);
        dat1 = 48'h0000_0000_000B;
        tick(1);
        req1 = 1'b0;
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("o_done0", 64'(done0), 1);
        tick(2);
        chk("o_start", 64'(write_start), 1);
        chk("o_grant", 64'(grant), 1);
        chk("o_dat", 64'(write_dat), 64'hB);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("o_done1", 64'(done1), 1);
        tick(4);
        chk("o_n_start", 64'(n_start - s_start), 2);
        chk("o_n_done1", 64'(n_done1 - s_done1), 1);

        // timeout
        snap();
        req0 = 1'b1; dat0 = 48'h1;
        tick(1);
        req0 = 1'b0;
        tick(1);
        chk("t_start", 64'(write_start), 1);
        chk("t_grant", 64'(grant), 0);
        tick(20);
        chk("t_c22_err", 64'(err0), 0);
        chk("t_c22_busy", 64'(busy), 1);
        tick(1);
        chk("t_err0", 64'(err0), 1);
        chk("t_done0", 64'(done0), 0);
        chk("t_busy", 64'(busy), 0);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        tick(1);
        chk("t_late_done", 64'(done0), 0);
        tick(3);
        chk("t_n_done", 64'(n_done0 - s_done0), 0);
        chk("t_n_err0", 64'(n_err0 - s_err0), 1);

        // write_over in the terminal timeout cycle
        snap();
        req0 = 1'b1; dat0 = 48'h2;
        tick(1);
        req0 = 1'b0;
        tick(1);
        chk("e_start", 64'(write_start), 1);
        tick(20);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("e_done0", 64'(done0), 1);
        chk("e_err0", 64'(err0), 0);
        tick(3);
        chk("e_n_err", 64'(n_err0 - s_err0), 0);

        // req0 in its own grant cycle
        snap();
        req0 = 1'b1; dat0 = 48'hE1;
        tick(1);
        dat0 = 48'hE2;
        tick(1);
        req0 = 1'b0;
        chk("g_dat1", 64'(write_dat), 64'hE1);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("g_done0a", 64'(done0), 1);
        tick(2);
        chk("g_start2", 64'(write_start), 1);
        chk("g_grant2", 64'(grant), 0);
        chk("g_dat2", 64'(write_dat), 64'hE2);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        tick(3);
        chk("g_n_done0", 64'(n_done0 - s_done0), 2);

        // reset mid-WAIT with req1 pending
        snap();
        req0 = 1'b1; dat0 = 48'h55;
        tick(1);
        req0 = 1'b0;
        tick(2);
        req1 = 1'b1; dat1 = 48'h66;
        tick(1);
        req1 = 1'b0;
        rst  = 1'b1;
        tick(1);
        rst  = 1'b0;
        chk("r_out", {57'd0, write_start, busy, done0, done1, err0, err1,
                      |write_dat}, 0);
        chk("r_grant", 64'(grant), 1);
        tick(6);
        chk("r_n_start", 64'(n_start - s_start), 1);
        chk("r_n_pulses", 64'((n_done0 - s_done0) + (n_done1 - s_done1)
                            + (n_err0 - s_err0) + (n_err1 - s_err1)), 0);
        req0 = 1'b1; dat0 = 48'h77;
        tick(1);
        req0 = 1'b0;
        tick(1);
        chk("r_start", 64'(write_start), 1);
        chk("r_dat", 64'(write_dat), 64'h77);
        chk("r_grant0", 64'(grant), 0);
        tick(1);
        write_over = 1'b1;
        tick(1);
        write_over = 1'b0;
        chk("r_done0", 64'(done0), 1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
